// File: rtl/shift_sequencer.sv
// shift_sequencer: two-requester round-robin controller that drives the nibble-serial shifter over eight cycles
module shift_sequencer #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  shift_op,
  output logic [2:0]  shift_counter,
  output logic [31:0] shift_a,
  output logic [4:0]  shift_b,
  input  logic [3:0]  shift_d
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [4:0]  b_q;
  logic [2:0]  cnt;
  logic        last;
  logic        grant0, grant1, take, legal;
  logic [3:0]  sel_op;
  logic [31:0] sel_a;
  logic [4:0]  sel_b;
  // last holds the previously granted requester; reset to 1 so requester 0 wins first
  always_comb begin
    grant1 = req1_valid && (!req0_valid || (RR_ENABLE && !last));
    grant0 = req0_valid && !grant1;
    take   = (state == IDLE) && (req0_valid || req1_valid);
    sel_op = grant1 ? req1_op : req0_op;
    sel_a  = grant1 ? req1_a : req0_a;
    sel_b  = grant1 ? req1_b : req0_b;
    legal  = sel_op inside {4'b0001, 4'b0101, 4'b1101};
  end
  assign req0_ready    = (state == IDLE) && grant0;
  assign req1_ready    = (state == IDLE) && grant1;
  assign rsp_valid     = (state == DONE);
  assign shift_op      = op_q;
  assign shift_a       = a_q;
  assign shift_b       = b_q;
  assign shift_counter = cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      last     <= 1'b1;
      rsp_id   <= 1'b0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          op_q     <= sel_op[3:2];
          a_q      <= sel_a;
          b_q      <= sel_b;
          cnt      <= '0;
          last     <= grant1;
          rsp_id   <= grant1;
          rsp_data <= '0;
          rsp_err  <= !legal;
          state    <= legal ? RUN : DONE;
        end
        RUN: begin
          rsp_data[{cnt, 2'b00} +: 4] <= shift_d;
          cnt   <= cnt + 3'd1;
          state <= (cnt == 3'd7) ? DONE : RUN;
        end
        DONE: state <= rsp_ready ? IDLE : DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Controller and arbiter for the nibble-serial barrel shifter (`tinyqv_shifter`). It accepts shift requests from two requesters, for example the core ALU and a coprocessor or peripheral port, and grants one at a time by round-robin. It latches the granted operands, steps the shifter's nibble index 0..7 over eight cycles, assembles the 32-bit result, and returns it on a single response channel with a valid/ready handshake.

Parameters:
- RR_ENABLE, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 always wins.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_op  in  4  ALU op: 0001 SLL, 0101 SRL, 1101 SRA
- req0_a  in  32  operand to shift
- req0_b  in  5  shift amount
- req1_valid / req1_ready / req1_op / req1_a / req1_b  as requester 0
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_id  out  1  index of the requester that owns the result
- rsp_data  out  32  shift result
- rsp_err  out  1  op was illegal; rsp_data = 0
- shift_op  out  2  to shifter, = latched op[3:2]
- shift_counter  out  3  to shifter, nibble index
- shift_a  out  32  to shifter, latched a
- shift_b  out  5  to shifter, latched b
- shift_d  in  4  from shifter, combinational nibble result for shift_counter

Behaviour:
- Reset values: all req*_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0, shift_counter 0, latched op/a/b 0, state IDLE, round-robin pointer set so requester 0 wins first.
- Reset is effective mid-operation: any in-flight result is discarded; a held response is dropped.
- States: IDLE, RUN, DONE.
- IDLE:
  - Arbitrate between the valid requesters.
  - req*_ready is combinational, asserted only for the winner, only in IDLE.
  - Round-robin: if both are valid, grant the one not granted last. The pointer updates only on an accepted handshake.
  - On handshake: latch op, a, b and id.
  - Legal op: go to RUN with counter = 0.
  - Illegal op (anything other than 0001, 0101, 1101): go directly to DONE with rsp_err = 1 and rsp_data = 0.
- RUN:
  - Each cycle, drive shift_counter = counter and write rsp_data[4*counter +: 4] <= shift_d.
  - Increment counter; the 3-bit value wraps 7 -> 0.
  - After the cycle with counter = 7, go to DONE.
  - Incoming requests are ignored (ready = 0).
- DONE:
  - rsp_valid = 1; rsp_data, rsp_id and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE. A new request is accepted no earlier than the following cycle.
- Latency:
  - Handshake in cycle T gives rsp_valid in cycle T+9 for a legal op, and T+1 for an illegal op.
  - Minimum spacing between accepts is 10 cycles.
- Requester rule: once req*_valid is raised, the requester holds it and its op/a/b stable until ready. The controller never depends on requester inputs after the handshake.
- shift_op, shift_a and shift_b come from the latched registers and are stable for all of RUN. In IDLE and DONE they hold their last values.
- Result equals `a << b` for SLL, `a >> b` for SRL, and `$signed(a) >>> b` for SRA.
- b = 0 returns a unchanged. b = 31 is the largest shift.

Test Plan:
- Single request: req0 SLL, a=0x00000001, b=31 -> rsp_valid exactly 9 cycles after accept; rsp_data=0x80000000, rsp_id=0, rsp_err=0.
- SRA vs SRL on req1: a=0x80000000, b=4 -> SRA gives 0xF8000000, SRL gives 0x08000000, rsp_id=1 for both.
- Simultaneous requests, both valid continuously (RR_ENABLE=1): grants alternate 0,1,0,1. With RR_ENABLE=0, requester 0 is granted every time.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid and rsp_data stay stable, both readies stay 0; release -> IDLE, next accept one cycle later.
- Illegal op 0011 on req0 -> rsp_valid at T+1, rsp_err=1, rsp_data=0, shift_counter never leaves 0.
- Reset pulse during RUN at counter=4 -> outputs return to reset values immediately, no response is emitted, and requester 0 wins the next simultaneous request.
